// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
// Shared definitions for the 1-to-4 TDM demultiplexer: framer FSM state
// encoding, channel count and slot-counter width.
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        SEEK = 1'b0,    // waiting for a frame_sync beat
        RUN  = 1'b1     // locked, filling slots 0..3
    } state_t;

endpackage : tdm_demux_pkg

// File: rtl/tdm_slot_dec.sv
// -----------------------------------------------------------------------------
// tdm_slot_dec
// Decodes the slot index plus a write enable into a one-hot write strobe for
// the staging registers.
//
// Ports:
//   slot_i   [SLOT_W-1:0]  slot to be written
//   we_i                   a beat is written this cycle
//   strobe_o [NUM_CH-1:0]  one-hot strobe, all zero when we_i = 0
// -----------------------------------------------------------------------------
module tdm_slot_dec
    import tdm_demux_pkg::*;
(
    input  logic [SLOT_W-1:0] slot_i,
    input  logic              we_i,
    output logic [NUM_CH-1:0] strobe_o
);

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        strobe_o = '0;
        if (we_i) begin
            strobe_o[slot_i] = 1'b1;
        end
    end

endmodule : tdm_slot_dec

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
// Splits a time-multiplexed sample stream into four parallel channels. A
// framer FSM locks onto frame_sync, collects slots 0..3 into staging
// registers and presents each complete frame on y0..y3 with a valid/ready
// handshake. A frame that completes while the previous one is still
// unconsumed is dropped (ovf). A frame_sync in the middle of a frame restarts
// the frame (sync_err).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   din [WIDTH-1:0]   sample stream
//   din_valid         din carries a sample (always accepted)
//   frame_sync        beat is slot 0 (qualified by din_valid)
//   y0..y3            channel samples of the last delivered frame
//   out_valid         y0..y3 hold an unconsumed frame
//   out_ready         consumer accepts the frame
//   sync_err          one-cycle pulse on a misplaced frame_sync
//   ovf               one-cycle pulse when a completed frame is dropped
//   ovf_cnt [7:0]     saturating ovf count (only with TDM_DEMUX_OVF_CNT_EN)
//
// Build option: define TDM_DEMUX_OVF_CNT_EN to add the ovf_cnt output.
// -----------------------------------------------------------------------------
module tdm_demux_1to4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sync_err,
    output logic             ovf
`ifdef TDM_DEMUX_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W-1:0] wr_slot;
    logic              wr_en;
    logic              resync;
    logic              frame_done;
    logic [NUM_CH-1:0] wr_strobe;

    logic [WIDTH-1:0]  stage_q [NUM_CH];
    logic [WIDTH-1:0]  y_q     [NUM_CH];
    logic [WIDTH-1:0]  y_d     [NUM_CH];
    logic              out_valid_q, out_valid_d;
    logic              sync_err_q, sync_err_d;
    logic              ovf_q, ovf_d;

    // ---------------- framer FSM: next state and slot write control ----------
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_en      = 1'b0;
        wr_slot    = '0;
        resync     = 1'b0;
        frame_done = 1'b0;
        if (din_valid) begin
            case (state_q)
                SEEK: begin
                    if (frame_sync) begin
                        wr_en   = 1'b1;
                        slot_d  = SLOT_W'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    wr_en = 1'b1;
                    if (frame_sync && slot_q != '0) begin
                        // Restart the frame: this beat becomes slot 0. The
                        // stale slots are overwritten before the next
                        // completion, so they need no explicit clear.
                        resync = 1'b1;
                        slot_d = SLOT_W'(1);
                    end else begin
                        wr_slot    = slot_q;
                        slot_d     = slot_q + 1'b1;
                        frame_done = (slot_q == SLOT_W'(NUM_CH - 1));
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    tdm_slot_dec u_slot_dec (
        .slot_i   (wr_slot),
        .we_i     (wr_en),
        .strobe_o (wr_strobe)
    );

    // ---------------- output stage: delivery, hold, drop ---------------------
    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        sync_err_d  = resync;
        ovf_d       = 1'b0;
        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                // The slot-3 sample is still on din; take it straight through.
                for (int i = 0; i < NUM_CH - 1; i++) begin
                    y_d[i] = stage_q[i];
                end
                y_d[NUM_CH-1] = din;
                out_valid_d   = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEEK;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            ovf_q       <= ovf_d;
            y_q         <= y_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the staging array is a small register file, not RAM, so it
            // is reset explicitly; a partial frame must not survive reset.
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_strobe[i]) begin
                    stage_q[i] <= din;
                end
            end
        end
    end

`ifdef TDM_DEMUX_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    // Counts alongside the ovf pulse and sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (ovf_d && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign ovf       = ovf_q;

endmodule : tdm_demux_1to4

// File: tb/tb_tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1to4
// Directed scenarios for tdm_demux_1to4 with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1to4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] y0, y1, y2, y3;
    logic       out_valid;
    logic       out_ready;
    logic       sync_err;
    logic       ovf;
`ifdef TDM_DEMUX_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tdm_demux_1to4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sync_err   (sync_err),
        .ovf        (ovf)
`ifdef TDM_DEMUX_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One valid beat; returns 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] d, input logic fs);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = fs;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({y0, y1, y2, y3} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_y: got %h expected %h", {y0, y1, y2, y3}, 32'h0);
        end
        n_tests++;
        if ({out_valid, sync_err, ovf} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", {out_valid, sync_err, ovf}, 3'b000);
        end
`ifdef TDM_DEMUX_OVF_CNT_EN
        n_tests++;
        if (ovf_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b expected 0", out_valid);
        end
        send(8'h44, 1'b0);
        n_tests++;
        if ({y0, y1, y2, y3} !== 32'h11223344) begin
            n_fail++;
            $display("FAIL basic_y: got %h expected %h", {y0, y1, y2, y3}, 32'h11223344);
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid: got %b expected 1", out_valid);
        end
        idle(1);
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== {1'b0, 32'h11223344}) begin
            n_fail++;
            $display("FAIL basic_consumed: got %h expected %h", {out_valid, y0, y1, y2, y3},
                     {1'b0, 32'h11223344});
        end
    endtask

    task automatic test_seek_ignore();
        do_reset();
        out_ready = 1'b0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seek_valid: got %b expected 0", out_valid);
        end
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        // A frame_sync without din_valid must not disturb the frame.
        din        = 8'hEE;
        frame_sync = 1'b1;
        idle(1);
        frame_sync = 1'b0;
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== {1'b1, 32'h01020304}) begin
            n_fail++;
            $display("FAIL seek_frame: got %h expected %h", {out_valid, y0, y1, y2, y3},
                     {1'b1, 32'h01020304});
        end
    endtask

    task automatic test_resync();
        int n_err;
        out_ready = 1'b1;
        idle(1);
        n_err = 0;
        send(8'h10, 1'b1);
        n_err += int'(sync_err);
        send(8'h20, 1'b0);
        n_err += int'(sync_err);
        send(8'h55, 1'b1);
        n_tests++;
        if (sync_err !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_pulse: got %b expected 1", sync_err);
        end
        n_err += int'(sync_err);
        send(8'h66, 1'b0);
        n_err += int'(sync_err);
        send(8'h77, 1'b0);
        n_err += int'(sync_err);
        send(8'h88, 1'b0);
        n_err += int'(sync_err);
        n_tests++;
        if (n_err != 1) begin
            n_fail++;
            $display("FAIL resync_count: got %0d expected 1", n_err);
        end
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== {1'b1, 32'h55667788}) begin
            n_fail++;
            $display("FAIL resync_frame: got %h expected %h", {out_valid, y0, y1, y2, y3},
                     {1'b1, 32'h55667788});
        end
    endtask

    task automatic test_overflow();
        int n_ovf;
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        n_ovf = 0;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), (i == 1 || i == 5));
            n_ovf += int'(ovf);
        end
        n_tests++;
        if (n_ovf != 1) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d expected 1", n_ovf);
        end
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== {1'b1, 32'h01020304}) begin
            n_fail++;
            $display("FAIL ovf_hold: got %h expected %h", {out_valid, y0, y1, y2, y3},
                     {1'b1, 32'h01020304});
        end
`ifdef TDM_DEMUX_OVF_CNT_EN
        n_tests++;
        if (ovf_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ovf_cnt: got %0d expected 1", ovf_cnt);
        end
`endif
        idle(1);
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_single_cycle: got %b expected 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        // Held frame 1..4 is still pending; handshake lands with completion.
        out_ready = 1'b0;
        send(8'h05, 1'b1);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        out_ready = 1'b1;
        send(8'h08, 1'b0);
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== {1'b1, 32'h05060708}) begin
            n_fail++;
            $display("FAIL b2b_frame: got %h expected %h", {out_valid, y0, y1, y2, y3},
                     {1'b1, 32'h05060708});
        end
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ovf: got %b expected 0", ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        send(8'h90, 1'b1);
        send(8'h91, 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== 33'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got %h expected %h", {out_valid, y0, y1, y2, y3}, 33'h0);
        end
        idle(2);
        rst_n = 1'b1;
        send(8'h92, 1'b0);
        send(8'h09, 1'b1);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        n_tests++;
        if ({out_valid, y0, y1, y2, y3} !== {1'b1, 32'h090A0B0C}) begin
            n_fail++;
            $display("FAIL midreset_frame: got %h expected %h", {out_valid, y0, y1, y2, y3},
                     {1'b1, 32'h090A0B0C});
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        idle(1);
        rst_n = 1'b1;
        test_basic();
        test_seek_ignore();
        test_resync();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux_1to4
